// File: rtl/progress_overlay.sv
// progress_overlay: stacked framed progress bars drawn as a 1-bit overlay mask.
// A shared, divider-free engine walks every channel in turn. For each channel
// it counts how many steps of max/BAR_W fit below current. The per-channel
// results are latched at the start of vblank, so a bar never changes while the
// visible part of a frame is being drawn.
module progress_overlay #(
   parameter int CHANNELS = 2,
   parameter int BAR_W    = 128,
   parameter int BAR_H    = 8,
   parameter int ROW_GAP  = 4,
   parameter int X_OFFSET = 68,
   parameter int Y_OFFSET = 20
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  ce_pix,
   input  logic                  hblank,
   input  logic                  vblank,
   input  logic [CHANNELS-1:0]   enable,
   input  logic [25*CHANNELS-1:0] current,
   input  logic [25*CHANNELS-1:0] max,
   output logic                  pix,
   output logic [1:0]            pix_ch
);

   localparam int         LOG2_BW = $clog2(BAR_W);
   localparam logic [8:0] BW9     = 9'(BAR_W);
   localparam logic [1:0] LAST_CH = 2'(CHANNELS - 1);

   // Engine state
   logic [1:0]  ch_sel_q, ch_sel_d;
   logic [24:0] acc_q, acc_d;
   logic [8:0]  iter_q, iter_d;
   logic [8:0]  calc_q [CHANNELS];
   logic [8:0]  calc_d [CHANNELS];

   // Display latch and raster state
   logic [8:0]  disp_q [CHANNELS];
   logic [8:0]  disp_d [CHANNELS];
   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic        hb_prev_q, hb_prev_d;
   logic        vb_prev_q, vb_prev_d;
   logic        frame_ok_q, frame_ok_d;   // set by the first vblank rise after reset
   logic        pix_q, pix_d;
   logic [1:0]  pix_ch_q, pix_ch_d;

   // Selected channel operands
   logic [24:0] cur_sel, max_sel, step;
   logic [31:0] rx, ry;
   logic        bar_on;

   // Pick the operands of the channel the engine is currently serving
   always_comb begin
      cur_sel = '0;
      max_sel = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (ch_sel_q == 2'(k)) begin
            cur_sel = current[25*k +: 25];
            max_sel = max[25*k +: 25];
         end
      end
   end

   assign step = max_sel >> LOG2_BW;

   // Progress engine: accumulate steps until current is reached or the bar is full
   always_comb begin
      ch_sel_d = ch_sel_q;
      acc_d    = acc_q + step;
      iter_d   = iter_q + 9'd1;
      for (int k = 0; k < CHANNELS; k++) calc_d[k] = calc_q[k];
      if ((acc_q >= cur_sel) || (iter_q == BW9)) begin
         for (int k = 0; k < CHANNELS; k++) begin
            if (ch_sel_q == 2'(k)) calc_d[k] = iter_q;
         end
         acc_d    = '0;
         iter_d   = '0;
         ch_sel_d = (ch_sel_q == LAST_CH) ? 2'd0 : ch_sel_q + 2'd1;
      end
   end

   // Raster counters, blank edge detection and the once-per-frame display latch
   always_comb begin
      h_cnt_d    = h_cnt_q;
      v_cnt_d    = v_cnt_q;
      hb_prev_d  = hb_prev_q;
      vb_prev_d  = vb_prev_q;
      frame_ok_d = frame_ok_q;
      for (int k = 0; k < CHANNELS; k++) disp_d[k] = disp_q[k];
      if (ce_pix) begin
         h_cnt_d = hblank ? 11'd0 : h_cnt_q + 11'd1;
         if (vblank) v_cnt_d = 11'd0;
         else if (hblank && !hb_prev_q) v_cnt_d = v_cnt_q + 11'd1;
         hb_prev_d = hblank;
         vb_prev_d = vblank;
         if (vblank && !vb_prev_q) begin
            // calc_q is the pre-edge value, so a same-cycle engine write is not seen
            for (int k = 0; k < CHANNELS; k++) disp_d[k] = calc_q[k];
            frame_ok_d = 1'b1;
         end
      end
   end

   // Pixel rule for the raster position present at this pixel enable
   always_comb begin
      pix_d    = pix_q;
      pix_ch_d = pix_ch_q;
      rx       = {21'd0, h_cnt_q} - 32'(X_OFFSET);
      ry       = '0;
      bar_on   = 1'b0;
      if (ce_pix) begin
         pix_d    = 1'b0;
         pix_ch_d = 2'd0;
         for (int k = 0; k < CHANNELS; k++) begin
            ry     = {21'd0, v_cnt_q} - 32'(Y_OFFSET + k * (BAR_H + ROW_GAP));
            bar_on = 1'b0;
            if ((ry < 32'(BAR_H)) && (rx < 32'(BAR_W + 4))) begin
               if ((ry == 32'd0) || (ry == 32'(BAR_H - 1))) bar_on = 1'b1;
               else if ((rx == 32'd0) || (rx == 32'(BAR_W + 3))) bar_on = 1'b1;
               else if ((ry != 32'd1) && (ry != 32'(BAR_H - 2)) && (rx >= 32'd2) &&
                        (rx < 32'd2 + {23'd0, disp_q[k]})) bar_on = 1'b1;
            end
            if (frame_ok_q && enable[k] && bar_on) begin
               pix_d    = 1'b1;
               pix_ch_d = 2'(k);
            end
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ch_sel_q   <= '0;
         acc_q      <= '0;
         iter_q     <= '0;
         h_cnt_q    <= '0;
         v_cnt_q    <= '0;
         hb_prev_q  <= 1'b0;
         vb_prev_q  <= 1'b0;
         frame_ok_q <= 1'b0;
         pix_q      <= 1'b0;
         pix_ch_q   <= '0;
         for (int k = 0; k < CHANNELS; k++) begin
            calc_q[k] <= '0;
            disp_q[k] <= '0;
         end
      end else begin
         ch_sel_q   <= ch_sel_d;
         acc_q      <= acc_d;
         iter_q     <= iter_d;
         h_cnt_q    <= h_cnt_d;
         v_cnt_q    <= v_cnt_d;
         hb_prev_q  <= hb_prev_d;
         vb_prev_q  <= vb_prev_d;
         frame_ok_q <= frame_ok_d;
         pix_q      <= pix_d;
         pix_ch_q   <= pix_ch_d;
         for (int k = 0; k < CHANNELS; k++) begin
            calc_q[k] <= calc_d[k];
            disp_q[k] <= disp_d[k];
         end
      end
   end

   assign pix    = pix_q;
   assign pix_ch = pix_ch_q;

endmodule

// File: tb/tb_progress_overlay.sv
// Testbench for progress_overlay: frames of synthetic video are driven while a
// behavioural model predicts the overlay from the bar/fill rules.
module tb_progress_overlay;

   localparam int CH = 2, BW = 128, BH = 8, RG = 4, XO = 68, YO = 20;
   localparam int LOG2_BW = 7;
   localparam int H_ACT = 204, H_TOT = 210, V_ACT = 41, V_BLK = 2;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            ce_pix = 1'b0;
   logic            hblank = 1'b0;
   logic            vblank = 1'b0;
   logic [CH-1:0]   enable = '0;
   logic [25*CH-1:0] cur_v = '0;
   logic [25*CH-1:0] max_v = '0;
   logic            pix;
   logic [1:0]      pix_ch;

   // clock / reset block
   always #5 clk = ~clk;

   progress_overlay #(.CHANNELS(CH), .BAR_W(BW), .BAR_H(BH), .ROW_GAP(RG),
                      .X_OFFSET(XO), .Y_OFFSET(YO)) dut (
      .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix), .hblank(hblank), .vblank(vblank),
      .enable(enable), .current(cur_v), .max(max_v), .pix(pix), .pix_ch(pix_ch)
   );

   int     n_tests = 0;
   int     n_fail  = 0;
   longint cyc = 0, chg_cyc = 0, rst_cyc = 0;

   // behavioural model state
   int h_m = 0, v_m = 0, rep_h = 0, rep_v = 0, ch_m = 0;
   bit hb_p = 0, vb_p = 0, ok_m = 0, known_m = 1, pix_m = 0, ce_seen = 0;
   int disp_m [CH];

   // captured DUT output for the first fill row of each bar
   bit cap_p22 [256];
   bit cap_p34 [256];
   int cap_c34 [256];
   bit line_ch1 [64];
   int cnt_on = 0;

   logic [25*CH-1:0] pend_cur, pend_max;

   // Fill length: number of max/BW steps needed to reach current, capped at BW
   function automatic int fill_of(longint cur, longint mx);
      longint stp, n;
      stp = mx >> LOG2_BW;
      if (cur == 0) return 0;
      if (stp == 0) return BW;
      n = (cur + stp - 1) / stp;
      return (n > BW) ? BW : int'(n);
   endfunction

   // Channel drawn at (h,v), or -1 when nothing is drawn
   function automatic int model_pix(int h, int v);
      int rx, ry, res;
      res = -1;
      rx = h - XO;
      for (int k = 0; k < CH; k++) begin
         ry = v - (YO + k * (BH + RG));
         if (ok_m && enable[k] && ry >= 0 && ry < BH && rx >= 0 && rx < BW + 4) begin
            if (ry == 0 || ry == BH - 1 || rx == 0 || rx == BW + 3) res = k;
            else if (ry != 1 && ry != BH - 2 && rx >= 2 && rx < 2 + disp_m[k]) res = k;
         end
      end
      return res;
   endfunction

   // model: advances on every clock, updating on pixel enables
   initial begin
      for (int k = 0; k < CH; k++) disp_m[k] = 0;
      forever begin
         @(posedge clk);
         cyc++;
         if (!reset_n) begin
            h_m = 0; v_m = 0; hb_p = 0; vb_p = 0; ok_m = 0; known_m = 1;
            pix_m = 0; ch_m = 0; ce_seen = 0; rst_cyc = cyc;
            for (int k = 0; k < CH; k++) disp_m[k] = 0;
         end else begin
            ce_seen = ce_pix;
            if (ce_pix) begin
               int r;
               r = model_pix(h_m, v_m);
               pix_m = (r >= 0);
               ch_m  = (r >= 0) ? r : 0;
               rep_h = h_m;
               rep_v = v_m;
               if (vblank && !vb_p) begin
                  known_m = (cyc - chg_cyc > 600) && (cyc - rst_cyc > 600);
                  for (int k = 0; k < CH; k++)
                     disp_m[k] = fill_of(longint'(cur_v[25*k +: 25]), longint'(max_v[25*k +: 25]));
                  ok_m = 1;
               end
               h_m = hblank ? 0 : (h_m + 1) % 2048;
               if (vblank) v_m = 0;
               else if (hblank && !hb_p) v_m = (v_m + 1) % 2048;
               hb_p = hblank;
               vb_p = vblank;
            end
         end
      end
   end

   // scoreboard: compare every cycle, capture rows for literal checks
   initial begin
      forever begin
         @(negedge clk);
         if (known_m) begin
            n_tests++;
            if (pix !== pix_m || pix_ch !== 2'(ch_m)) begin
               n_fail++;
               if (n_fail <= 20)
                  $display("FAIL pix_cmp t=%0t h=%0d v=%0d got pix=%0b ch=%0d want pix=%0b ch=%0d",
                           $time, rep_h, rep_v, pix, pix_ch, pix_m, ch_m);
            end
         end
         if (ce_seen && reset_n) begin
            if (rep_v == 22 && rep_h < 256) cap_p22[rep_h] = pix;
            if (rep_v == 34 && rep_h < 256) begin
               cap_p34[rep_h] = pix;
               cap_c34[rep_h] = int'(pix_ch);
            end
            if (pix && pix_ch == 2'd1 && rep_v < 64) line_ch1[rep_v] = 1;
            if (pix) cnt_on++;
         end
      end
   end

   task automatic check_val(input string nm, input longint got, input longint want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s got=%0d want=%0d", nm, got, want);
      end
   endtask

   // one comparison: every captured pixel of a row in [lo,hi] must equal val
   task automatic check_run(input string nm, input int row, input int lo, input int hi,
                            input bit val);
      int bad;
      bit b;
      bad = -1;
      for (int h = lo; h <= hi; h++) begin
         b = (row == 22) ? cap_p22[h] : cap_p34[h];
         if (b != val && bad < 0) bad = h;
      end
      n_tests++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s row=%0d h=%0d got=%0b want=%0b", nm, row, bad, ~val, val);
      end
   endtask

   // driver: one pixel, optionally preceded by idle clocks without ce_pix
   task automatic pix_step(input bit hb, input bit vb, input int mode);
      int gap;
      gap = (mode == 0) ? 0 : $urandom_range(0, 3);
      for (int i = 0; i < gap; i++) begin
         @(negedge clk);
         ce_pix = 1'b0;
      end
      @(negedge clk);
      ce_pix = 1'b1;
      hblank = hb;
      vblank = vb;
   endtask

   // driver: one frame (vblank lines then active lines)
   task automatic run_frame(input int mode, input int chg_line, input int rst_line,
                            input logic [CH-1:0] en);
      enable = en;
      for (int i = 0; i < 256; i++) begin
         cap_p22[i] = 0; cap_p34[i] = 0; cap_c34[i] = 0;
      end
      for (int i = 0; i < 64; i++) line_ch1[i] = 0;
      cnt_on = 0;
      for (int l = 0; l < V_BLK; l++)
         for (int p = 0; p < H_TOT; p++) pix_step(p >= H_ACT, 1'b1, mode);
      for (int l = 0; l < V_ACT; l++) begin
         if (l == rst_line) reset_n = 1'b1;
         if (l == chg_line) begin
            cur_v = pend_cur;
            max_v = pend_max;
            chg_cyc = cyc;
         end
         for (int p = 0; p < H_TOT; p++) pix_step(p >= H_ACT, 1'b0, mode);
      end
   endtask

   function automatic logic [25*CH-1:0] pack2(longint a0, longint a1);
      logic [24:0] x0, x1;
      x0 = 25'(a0);
      x1 = 25'(a1);
      return {x1, x0};
   endfunction

   initial begin
      longint m0, m1;
      cur_v = pack2(640, 3);
      max_v = pack2(1280, 1280);
      enable = 2'b01;
      repeat (3) @(negedge clk);
      check_val("reset_pix", longint'(pix), 0);
      check_val("reset_pix_ch", longint'(pix_ch), 0);

      // F0: video runs under reset, released mid-frame
      run_frame(0, -1, 10, 2'b01);
      check_val("post_reset_blank", cnt_on, 0);

      // F1: single bar 640/1280 -> 64
      pend_cur = pack2(0, 5000);
      pend_max = pack2(1280, 1280);
      run_frame(0, 0, -1, 2'b01);
      check_run("f1_pre", 22, 0, 67, 0);
      check_run("f1_lborder", 22, 68, 68, 1);
      check_run("f1_gap", 22, 69, 69, 0);
      check_run("f1_fill", 22, 70, 133, 1);
      check_run("f1_empty", 22, 134, 198, 0);
      check_run("f1_rborder", 22, 199, 199, 1);
      check_run("f1_bar1_off", 34, 0, 203, 0);

      // F2: empty fill on bar 0, clamped full fill on bar 1
      pend_cur = pack2(256, 768);
      pend_max = pack2(1024, 1024);
      run_frame(0, 0, -1, 2'b11);
      check_run("f2_b0_lb", 22, 68, 68, 1);
      check_run("f2_b0_empty", 22, 69, 198, 0);
      check_run("f2_b0_rb", 22, 199, 199, 1);
      check_run("f2_b1_fill", 34, 70, 197, 1);
      check_run("f2_b1_gap", 34, 198, 198, 0);
      check_val("f2_b1_ch", cap_c34[100], 1);

      // F3: 25% and 75%
      run_frame(0, -1, -1, 2'b11);
      check_run("f3_b0_fill", 22, 70, 101, 1);
      check_run("f3_b0_empty", 22, 102, 198, 0);
      check_run("f3_b1_fill", 34, 70, 165, 1);
      check_run("f3_b1_empty", 34, 166, 198, 0);
      check_val("f3_ch1_row31", line_ch1[31], 0);
      check_val("f3_ch1_row32", line_ch1[32], 1);
      check_val("f3_ch1_row39", line_ch1[39], 1);
      check_val("f3_ch1_row40", line_ch1[40], 0);

      // F4: bar 1 disabled; inputs change mid-frame, display must not
      pend_cur = pack2(1024, 1);
      pend_max = pack2(1024, 50);
      run_frame(0, 10, -1, 2'b01);
      check_run("f4_b0_fill", 22, 70, 101, 1);
      check_run("f4_b0_empty", 22, 102, 198, 0);
      check_run("f4_b1_off", 34, 0, 203, 0);

      // F5: new values visible, irregular pixel enables
      m0 = $urandom_range(1, 1 << 20);
      m1 = $urandom_range(1, 1 << 20);
      pend_cur = pack2($urandom_range(0, int'(m0 + m0 / 4)), $urandom_range(0, int'(m1 + m1 / 4)));
      pend_max = pack2(m0, m1);
      run_frame(1, 0, -1, 2'b11);
      check_run("f5_b0_full", 22, 70, 197, 1);
      check_run("f5_b1_full", 34, 70, 197, 1);

      // F6: random values, random enables, model-checked only
      m0 = $urandom_range(1, 1 << 20);
      m1 = $urandom_range(1, 1 << 20);
      pend_cur = pack2($urandom_range(0, int'(m0)), $urandom_range(0, int'(m1)));
      pend_max = pack2(m0, m1);
      run_frame(0, 5, -1, 2'($urandom_range(0, 3)));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
